// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit: a single req/ack channel
// carrying one doubleword-aligned read or byte-strobed write.
interface load_store_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_wstrb,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_wstrb,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit for the RV64I pipeline.
// Runs one req/ack transaction per load/store, stalls IF..M while it is in
// flight, aligns store data into byte lanes, extracts and extends load data,
// flags misaligned/illegal accesses and declares a bus error on timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_M,
    input  logic                     ld_M,
    input  logic                     st_M,
    input  logic [2:0]               funct3_M,
    input  logic [63:0]              alu_out_M,
    input  logic [63:0]              st_data_M,
    output logic [63:0]              ld_data_M,
    output logic                     stall_M,
    output logic                     mem_done_M,
    output logic                     fault_M,
    output logic                     bus_err_M,
    load_store_unit_if.master        dmem
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Last wait-counter value before the timeout fires; the counter starts
    // at 0 in the first REQ cycle, so REQ lasts exactly TIMEOUT cycles.
    localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_wait;
    logic [2:0]  r_funct3;
    logic [2:0]  r_off;
    logic [63:0] r_ld_data;
    logic        r_done;
    logic        r_bus_err;
    logic        r_req;
    logic        r_we;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [7:0]  r_wstrb;

    logic        w_mem_op;
    logic [2:0]  w_off;
    logic        w_fault;
    logic        w_accept;

    // Access size is funct3[1:0]; the offset must be a multiple of it.
    function automatic logic f_misaligned(input logic [2:0] f3, input logic [2:0] off);
        logic w_mis;
        case (f3[1:0])
            2'b00:   w_mis = 1'b0;
            2'b01:   w_mis = off[0];
            2'b10:   w_mis = |off[1:0];
            default: w_mis = |off;
        endcase
        return w_mis;
    endfunction

    // Byte write enables for a store of size funct3[1:0] at lane off.
    function automatic logic [7:0] f_wstrb(input logic [2:0] f3, input logic [2:0] off);
        logic [7:0] w_strb;
        case (f3[1:0])
            2'b00:   w_strb = 8'h01 << off;
            2'b01:   w_strb = 8'h03 << off;
            2'b10:   w_strb = 8'h0F << off;
            default: w_strb = 8'hFF;
        endcase
        return w_strb;
    endfunction

    // Pull the addressed lane down to bit 0, then sign- or zero-extend.
    function automatic logic [63:0] f_load(input logic [2:0] f3, input logic [2:0] off,
                                           input logic [63:0] rdata);
        logic [63:0] w_sh;
        logic [63:0] w_res;
        w_sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  w_res = {{56{w_sh[7]}},  w_sh[7:0]};
            3'b001:  w_res = {{48{w_sh[15]}}, w_sh[15:0]};
            3'b010:  w_res = {{32{w_sh[31]}}, w_sh[31:0]};
            3'b011:  w_res = w_sh;
            3'b100:  w_res = {56'd0, w_sh[7:0]};
            3'b101:  w_res = {48'd0, w_sh[15:0]};
            3'b110:  w_res = {32'd0, w_sh[31:0]};
            default: w_res = 64'd0;
        endcase
        return w_res;
    endfunction

    assign w_mem_op = valid_M & (ld_M | st_M);
    assign w_off    = alu_out_M[2:0];

    // Fault is only meaningful when a new op is being considered in IDLE.
    assign w_fault  = w_mem_op & (r_state == S_IDLE) &
                      (f_misaligned(funct3_M, w_off) |
                       (ld_M & (funct3_M == 3'b111)) |
                       (st_M & funct3_M[2]));
    assign w_accept = w_mem_op & ~w_fault;

    // Stall in IDLE is decided from the M-stage inputs the same cycle;
    // both flags are forced low while reset is held.
    assign fault_M  = w_fault & ~rst;
    assign stall_M  = ~rst & (((r_state == S_IDLE) & w_accept) | (r_state == S_REQ));

    assign ld_data_M       = r_ld_data;
    assign mem_done_M      = r_done;
    assign bus_err_M       = r_bus_err;
    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_wdata = r_wdata;
    assign dmem.dmem_wstrb = r_wstrb;

    // Transaction FSM: latch the request in IDLE, hold it through REQ until
    // ack or timeout, then present the result for one DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wait    <= 8'd0;
            r_funct3  <= 3'd0;
            r_off     <= 3'd0;
            r_ld_data <= 64'd0;
            r_done    <= 1'b0;
            r_bus_err <= 1'b0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 64'd0;
            r_wdata   <= 64'd0;
            r_wstrb   <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done    <= 1'b0;
                    r_bus_err <= 1'b0;
                    if (w_accept) begin
                        r_state  <= S_REQ;
                        r_wait   <= 8'd0;
                        r_req    <= 1'b1;
                        r_we     <= st_M;
                        r_addr   <= {alu_out_M[63:3], 3'b000};
                        r_wdata  <= st_M ? (st_data_M << {w_off, 3'b000}) : 64'd0;
                        r_wstrb  <= st_M ? f_wstrb(funct3_M, w_off) : 8'd0;
                        r_funct3 <= funct3_M;
                        r_off    <= w_off;
                    end
                end
                S_REQ: begin
                    if (dmem.dmem_ack) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_ld_data <= r_we ? 64'd0 : f_load(r_funct3, r_off, dmem.dmem_rdata);
                        r_req     <= 1'b0;
                        r_we      <= 1'b0;
                        r_addr    <= 64'd0;
                        r_wdata   <= 64'd0;
                        r_wstrb   <= 8'd0;
                    end else if (r_wait == LP_WAIT_LAST) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_bus_err <= 1'b1;
                        r_ld_data <= 64'd0;
                        r_req     <= 1'b0;
                        r_we      <= 1'b0;
                        r_addr    <= 64'd0;
                        r_wdata   <= 64'd0;
                        r_wstrb   <= 8'd0;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_done    <= 1'b0;
                    r_bus_err <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed cases followed by random
// loads/stores against a memory responder with random ack latency.
module tb_load_store_unit;

    localparam int TO = 4;

    typedef struct {
        int          delay;
        bit          noack;
        logic [63:0] rdata;
    } job_t;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } req_t;

    typedef struct {
        logic [63:0] ld;
        logic        berr;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic        valid_M;
    logic        ld_M;
    logic        st_M;
    logic [2:0]  funct3_M;
    logic [63:0] alu_out_M;
    logic [63:0] st_data_M;
    logic [63:0] ld_data_M;
    logic        stall_M;
    logic        mem_done_M;
    logic        fault_M;
    logic        bus_err_M;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_M    (valid_M),
        .ld_M       (ld_M),
        .st_M       (st_M),
        .funct3_M   (funct3_M),
        .alu_out_M  (alu_out_M),
        .st_data_M  (st_data_M),
        .ld_data_M  (ld_data_M),
        .stall_M    (stall_M),
        .mem_done_M (mem_done_M),
        .fault_M    (fault_M),
        .bus_err_M  (bus_err_M),
        .dmem       (bus.master)
    );

    job_t jobq[$];
    req_t reqq[$];
    rsp_t rspq[$];

    int checks = 0;
    int errors = 0;
    bit resp_en = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference rules, written in terms of access size in bytes.
    function automatic bit m_fault(input bit ld, input bit st, input int f3, input logic [63:0] addr);
        int nb;
        nb = 1 << (f3 % 4);
        if (!(ld || st)) return 1'b0;
        if (ld && f3 == 7) return 1'b1;
        if (st && f3 >= 4) return 1'b1;
        return (addr % nb) != 0;
    endfunction

    function automatic logic [63:0] m_load(input int f3, input int off, input logic [63:0] rdata);
        int nb;
        logic [63:0] v;
        nb = 1 << (f3 % 4);
        v = rdata >> (8 * off);
        if (nb == 8) return v;
        v = v % (64'd1 << (8 * nb));
        if (f3 < 4 && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
        return v;
    endfunction

    // Present one M-stage instruction, hold it while stalled, and check the
    // fault flag plus the number of stall and request cycles.
    task automatic run_op(input bit v, input bit ld, input bit st, input int f3,
                          input logic [63:0] addr, input logic [63:0] sdata,
                          input int delay, input bit noack, input logic [63:0] rdata);
        bit   mem;
        bit   flt;
        int   off;
        int   nb;
        int   s;
        int   stalls;
        int   reqs;
        req_t rq;
        rsp_t rs;
        job_t jb;
        off = int'(addr[2:0]);
        nb  = 1 << (f3 % 4);
        mem = v && (ld || st);
        flt = v && m_fault(ld, st, f3, addr);
        if (mem && !flt) begin
            s        = ((1 << nb) - 1) << off;
            rq.we    = st;
            rq.addr  = addr - (addr % 8);
            rq.wdata = st ? (sdata << (8 * off)) : 64'd0;
            rq.wstrb = st ? s[7:0] : 8'd0;
            rs.berr  = noack;
            rs.ld    = (noack || st) ? 64'd0 : m_load(f3, off, rdata);
            jb.delay = delay;
            jb.noack = noack;
            jb.rdata = rdata;
            jobq.push_back(jb);
            reqq.push_back(rq);
            rspq.push_back(rs);
        end
        @(posedge clk);
        #1;
        valid_M   = v;
        ld_M      = ld;
        st_M      = st;
        funct3_M  = 3'(f3);
        alu_out_M = addr;
        st_data_M = sdata;
        @(negedge clk);
        chk("fault_M", 64'(fault_M), 64'(flt));
        stalls = 0;
        reqs   = 0;
        while (stall_M) begin
            stalls++;
            if (bus.dmem_req) reqs++;
            if (stalls > 50) break;
            @(negedge clk);
        end
        if (!mem || flt) begin
            chk("stall_cycles", 64'(stalls), 64'd0);
            chk("req_cycles", 64'(reqs), 64'd0);
        end else if (noack) begin
            chk("stall_cycles", 64'(stalls), 64'(1 + TO));
            chk("req_cycles", 64'(reqs), 64'(TO));
        end else begin
            chk("stall_cycles", 64'(stalls), 64'(2 + delay));
            chk("req_cycles", 64'(reqs), 64'(1 + delay));
        end
        if (flt) begin
            @(negedge clk);
            chk("fault_no_req", 64'(bus.dmem_req), 64'd0);
        end
    endtask

    // Memory responder: acks after the per-op delay, or never for timeouts.
    initial begin : responder
        job_t jb;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 64'd0;
        forever begin
            @(negedge clk);
            if (!resp_en || !bus.dmem_req || rst) continue;
            if (jobq.size() == 0) begin
                chk("job_available", 64'(jobq.size()), 64'd1);
                while (bus.dmem_req) @(negedge clk);
                continue;
            end
            jb = jobq.pop_front();
            for (int i = 0; i < jb.delay; i++) @(negedge clk);
            if (!jb.noack) begin
                bus.dmem_ack   = 1'b1;
                bus.dmem_rdata = jb.rdata;
                @(negedge clk);
                bus.dmem_ack   = 1'b0;
                bus.dmem_rdata = {$urandom(), $urandom()};
            end else begin
                while (bus.dmem_req) @(negedge clk);
            end
        end
    end

    // Monitor: compares request fields every REQ cycle and results on DONE.
    initial begin : monitor
        bit   prev;
        req_t cur;
        rsp_t e;
        prev = 1'b0;
        cur  = '{we: 1'b0, addr: 64'd0, wdata: 64'd0, wstrb: 8'd0};
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
                continue;
            end
            if (bus.dmem_req) begin
                if (!prev) begin
                    chk("req_expected", 64'(reqq.size() != 0), 64'd1);
                    if (reqq.size() != 0) cur = reqq.pop_front();
                end
                chk("dmem_we", 64'(bus.dmem_we), 64'(cur.we));
                chk("dmem_addr", bus.dmem_addr, cur.addr);
                chk("dmem_wdata", bus.dmem_wdata, cur.wdata);
                chk("dmem_wstrb", 64'(bus.dmem_wstrb), 64'(cur.wstrb));
            end
            if (mem_done_M) begin
                chk("done_expected", 64'(rspq.size() != 0), 64'd1);
                if (rspq.size() != 0) begin
                    e = rspq.pop_front();
                    chk("ld_data_M", ld_data_M, e.ld);
                    chk("bus_err_M", 64'(bus_err_M), 64'(e.berr));
                end
            end
            prev = bus.dmem_req;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : stimulus
        bit          v;
        bit          ld;
        bit          st;
        int          f3;
        int          nb;
        int          off;
        int          kind;
        int          delay;
        bit          noack;
        logic [63:0] addr;
        logic [63:0] sdata;
        logic [63:0] rdata;
        rq_init: begin end
        rst       = 1'b1;
        valid_M   = 1'b1;
        ld_M      = 1'b1;
        st_M      = 1'b0;
        funct3_M  = 3'b010;
        alu_out_M = 64'h4002;
        st_data_M = 64'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ld_data", ld_data_M, 64'd0);
        chk("rst_stall", 64'(stall_M), 64'd0);
        chk("rst_fault", 64'(fault_M), 64'd0);
        chk("rst_done", 64'(mem_done_M), 64'd0);
        chk("rst_bus_err", 64'(bus_err_M), 64'd0);
        chk("rst_req", 64'(bus.dmem_req), 64'd0);
        chk("rst_we", 64'(bus.dmem_we), 64'd0);
        chk("rst_addr", bus.dmem_addr, 64'd0);
        chk("rst_wdata", bus.dmem_wdata, 64'd0);
        chk("rst_wstrb", 64'(bus.dmem_wstrb), 64'd0);
        valid_M = 1'b0;
        rst     = 1'b0;

        // Directed cases.
        run_op(1, 1, 0, 0, 64'h1003, 64'd0, 0, 0, 64'h00000000_80000000);
        run_op(1, 0, 1, 1, 64'h3006, 64'hBEEF, 3, 0, 64'd0);
        run_op(1, 1, 0, 2, 64'h4002, 64'd0, 0, 0, 64'd0);
        run_op(1, 1, 0, 3, 64'h6000, 64'd0, 0, 1, 64'd0);
        run_op(1, 1, 0, 6, 64'h2004, 64'd0, 0, 0, 64'h89ABCDEF_01234567);
        run_op(1, 0, 0, 0, 64'h7000, 64'd0, 0, 0, 64'd0);

        // Reset in the second REQ cycle of an LD; responder stays quiet.
        resp_en = 1'b0;
        reqq.push_back('{we: 1'b0, addr: 64'h5008, wdata: 64'd0, wstrb: 8'd0});
        @(posedge clk);
        #1;
        valid_M   = 1'b1;
        ld_M      = 1'b1;
        st_M      = 1'b0;
        funct3_M  = 3'b011;
        alu_out_M = 64'h5008;
        @(negedge clk);
        chk("ld_data_hold", ld_data_M, 64'h00000000_89ABCDEF);
        @(posedge clk);
        @(negedge clk);
        chk("rstreq_req1", 64'(bus.dmem_req), 64'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rstreq_req", 64'(bus.dmem_req), 64'd0);
        chk("rstreq_stall", 64'(stall_M), 64'd0);
        chk("rstreq_ld_data", ld_data_M, 64'd0);
        chk("rstreq_addr", bus.dmem_addr, 64'd0);
        chk("rstreq_done", 64'(mem_done_M), 64'd0);
        valid_M = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 64'hDEADBEEF_CAFEF00D;
        @(negedge clk);
        chk("late_ack_req", 64'(bus.dmem_req), 64'd0);
        @(posedge clk);
        #1;
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_done", 64'(mem_done_M), 64'd0);
        chk("late_ack_stall", 64'(stall_M), 64'd0);
        resp_en = 1'b1;
        run_op(1, 1, 0, 3, 64'h5008, 64'd0, 1, 0, 64'h01234567_89ABCDEF);

        // Random traffic, back to back.
        for (int n = 0; n < 200; n++) begin
            kind  = $urandom_range(0, 9);
            ld    = (kind <= 4);
            st    = (kind >= 5 && kind <= 8);
            v     = ($urandom_range(0, 7) != 0);
            f3    = $urandom_range(0, 7);
            if (st && $urandom_range(0, 5) != 0) f3 = f3 % 4;
            nb    = 1 << (f3 % 4);
            off   = $urandom_range(0, 7);
            if ($urandom_range(0, 3) != 0) off = off - (off % nb);
            addr  = {$urandom(), $urandom()};
            addr[2:0] = 3'(off);
            sdata = {$urandom(), $urandom()};
            rdata = {$urandom(), $urandom()};
            delay = $urandom_range(0, TO - 1);
            noack = ($urandom_range(0, 7) == 0);
            run_op(v, ld, st, f3, addr, sdata, delay, noack, rdata);
        end

        @(posedge clk);
        #1;
        valid_M = 1'b0;
        repeat (3) @(negedge clk);
        chk("rsp_left", 64'(rspq.size()), 64'd0);
        chk("req_left", 64'(reqq.size()), 64'd0);
        chk("job_left", 64'(jobq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
